cp0_regfile: RTL
================

Name: cp0_regfile

Overview:
- Coprocessor-0 register file consuming the commit-stage exception unit's outputs: exp_en, exl_clean, epc, code, bad_vaddr, bd.
- Feeds back to the exception unit: allow_interrupt, masked pending-interrupt vector and EPC for eret redirect.
- Serves mfc0 reads combinationally and commits mtc0 writes from the same stage.
- Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15).

Parameters:
PRID_VALUE, 32'h0001_8000, constant returned on reads of register 15 sel 0.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
ex_mem_stall  input  1  commit stage stalled; no exception/eret/mtc0 commits while high
hw_int  input  6  external hardware interrupt lines, level-sensitive
exp_en  input  1  exception commit request
exl_clean  input  1  eret commit request
exp_epc  input  32  EPC value for the exception
exp_code  input  5  ExcCode
exp_bd  input  1  faulting instruction is in a delay slot
bad_vaddr  input  32  faulting virtual address
bad_vaddr_wen  input  1  update BadVAddr
wen  input  1  mtc0 write enable
waddr  input  5  mtc0 register number
wsel  input  3  mtc0 select
wdata  input  32  mtc0 data
raddr  input  5  mfc0 register number
rsel  input  3  mfc0 select
rdata  output  32  mfc0 data, combinational from raddr/rsel
allow_interrupt  output  1  Status.IE & ~Status.EXL
interrupt_flag  output  8  Cause.IP[15:8] & Status.IM[15:8]
epc_address  output  32  current EPC

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - Status=32'h0040_0000 (BEV=1). Cause, EPC, BadVAddr, Count, Compare, tick flop all 0.
  - Resulting outputs: allow_interrupt=0, interrupt_flag=0, epc_address=0.
  - Reset overrides everything, including a commit in the same cycle.
- Commit = signal high and ex_mem_stall=0.
- Priority per cycle: exception commit > eret commit > mtc0 write. The lower-priority request is dropped, not deferred.
- Exception commit:
  - Cause.ExcCode[6:2] <= exp_code; Status.EXL <= 1.
  - If Status.EXL was 0: EPC <= exp_epc and Cause.BD[31] <= exp_bd. If EXL was already 1: EPC and BD unchanged.
  - If bad_vaddr_wen: BadVAddr <= bad_vaddr.
- Eret commit: Status.EXL <= 0. Nothing else changes.
- mtc0 write (sel 0 only; other sels ignored):
  - Status: only IM[15:8], EXL[1], IE[0] writable; BEV reads 1.
  - Cause: only IP[9:8] (software interrupts) writable.
  - EPC: full 32 bits.
  - Count: loads wdata and clears the tick flop.
  - Compare: loads wdata and clears Cause.TI[30].
  - BadVAddr, PRId and unknown registers: writes ignored.
- Cause.IP[15:10] is registered from hw_int[5:0] every cycle, including during stall. interrupt_flag therefore lags hw_int by 1 cycle.
- Count:
  - tick toggles every cycle; Count increments when tick=1, so +1 every 2 cycles. Not gated by stall.
  - Wraps 32'hFFFF_FFFF -> 0 silently.
- Reads: registers 8, 9, 11, 12, 13, 14 and 15 (sel 0) return their current register values, with no bypass of a same-cycle write. Any other addr/sel returns 0. Cause bits outside BD/TI/IP/ExcCode read 0.
- epc_address and allow_interrupt reflect register state, so an update is visible the cycle after commit.

Optional Feature:
CP0_TIMER_INT_EN
- Defined:
  - TI sets the cycle after Count==Compare, when a Count increment lands on Compare; a Count write that equals Compare does not set it.
  - TI is sticky until a Compare write clears it.
  - Cause.IP[15] = hw_int[5] registered OR TI.
- Undefined: Compare is absent (reads 0, writes ignored), TI reads 0, and IP[15] follows hw_int[5] only. Count still runs.

Decomposition:
- cp0_pkg holds:
  - register-number localparams: CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15.
  - STATUS_RESET, the Status/Cause bit-position constants, the writable-bit masks, and the ExcCode enum (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, CPU=11, OV=12).
- One sub-module, cp0_timer: tick flop, Count, Compare, TI. It exposes count_wen/compare_wen/wdata and outputs count, compare, ti.

Test Plan:
- Reset then read 12 -> rdata=32'h0040_0000; allow_interrupt=0; interrupt_flag=8'h00.
- mtc0 Status=32'h0000_FF01, then mtc0 Cause=32'h0000_0100 -> allow_interrupt=1, interrupt_flag=8'h01 next cycle; read Cause=32'h0000_0100.
- exp_en with epc=32'hBFC0_0100, code=5'h04, bd=1, bad_vaddr_wen=1, bad_vaddr=32'h0000_0003 ->
  - EPC=32'hBFC0_0100; Cause=32'h8000_0010; BadVAddr=32'h0000_0003; EXL=1; allow_interrupt=0.
  - A second exp_en with epc=32'h1234 leaves EPC unchanged and updates ExcCode only.
- exp_en and wen (EPC=32'hDEAD) in the same cycle -> EPC=exp_epc.
  - Same inputs with ex_mem_stall=1 -> no register changes.
  - Then exl_clean -> EXL=0 and epc_address unchanged.
- Count: write 0 -> reads 5 after 10 cycles. Write 32'hFFFF_FFFF -> reads 0 two cycles later.
- CP0_TIMER_INT_EN defined:
  - Compare=20, Count=0, IM7 set -> TI=1 and interrupt_flag[7]=1 at cycle 41 after the Count write.
  - A Compare write clears it.
  - With the macro undefined, interrupt_flag[7] stays 0 with hw_int=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, bit positions, write masks and exception codes
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_BEV   = 22;

    localparam int CAUSE_EXC_LO   = 2;
    localparam int CAUSE_EXC_HI   = 6;
    localparam int CAUSE_IP_LO    = 8;
    localparam int CAUSE_IP_SW_HI = 9;
    localparam int CAUSE_IP_HI    = 15;
    localparam int CAUSE_TI       = 30;
    localparam int CAUSE_BD       = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_CPU  = 5'd11,
        EXC_OV   = 5'd12
    } exc_code_e;

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer; timer interrupt built only with CP0_TIMER_INT_EN
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_wen,
    input  logic        compare_wen,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic tick;

    // Count advances on every other cycle; a Count write restarts the half-rate phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick  <= 1'b0;
            count <= '0;
        end else if (count_wen) begin
            tick  <= 1'b0;
            count <= wdata;
        end else begin
            tick <= ~tick;
            if (tick) begin
                count <= count + 32'd1;
            end
        end
    end

`ifdef CP0_TIMER_INT_EN
    logic hit;

    // hit marks an increment landing on Compare; TI follows one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= '0;
            ti      <= 1'b0;
            hit     <= 1'b0;
        end else begin
            hit <= tick & ~count_wen & ~compare_wen & ((count + 32'd1) == compare);
            if (compare_wen) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (hit) begin
                ti <= 1'b1;
            end
        end
    end
`else
    logic unused_compare_wen;
    assign unused_compare_wen = compare_wen;
    assign compare = '0;
    assign ti      = 1'b0;
`endif

endmodule

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file (timer interrupt enabled by CP0_TIMER_INT_EN)
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0001_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_stall,
    input  logic [5:0]  hw_int,
    input  logic        exp_en,
    input  logic        exl_clean,
    input  logic [31:0] exp_epc,
    input  logic [4:0]  exp_code,
    input  logic        exp_bd,
    input  logic [31:0] bad_vaddr,
    input  logic        bad_vaddr_wen,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [2:0]  wsel,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    output logic        allow_interrupt,
    output logic [7:0]  interrupt_flag,
    output logic [31:0] epc_address
);

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic        cause_bd_q;
    logic [4:0]  cause_exc_q;
    logic [1:0]  ip_sw_q;
    logic [5:0]  ip_hw_q;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [7:0]  cause_ip;
    logic [31:0] cause_rd;

    logic exc_commit;
    logic eret_commit;
    logic mtc0_commit;
    logic count_wen;
    logic compare_wen;

    // Exception beats eret beats mtc0; losers are dropped for this cycle.
    assign exc_commit  = exp_en & ~ex_mem_stall;
    assign eret_commit = exl_clean & ~ex_mem_stall & ~exp_en;
    assign mtc0_commit = wen & ~ex_mem_stall & ~exp_en & ~exl_clean & (wsel == 3'd0);

    assign count_wen   = mtc0_commit & (waddr == CP0_COUNT);
    assign compare_wen = mtc0_commit & (waddr == CP0_COMPARE);

    cp0_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .count_wen   (count_wen),
        .compare_wen (compare_wen),
        .wdata       (wdata),
        .count       (count),
        .compare     (compare),
        .ti          (ti)
    );

    assign cause_ip = {ip_hw_q[5] | ti, ip_hw_q[4:0], ip_sw_q};
    assign cause_rd = {cause_bd_q, ti, 14'd0, cause_ip, 1'b0, cause_exc_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= STATUS_RESET;
            epc_q       <= '0;
            badvaddr_q  <= '0;
            cause_bd_q  <= 1'b0;
            cause_exc_q <= '0;
            ip_sw_q     <= '0;
            ip_hw_q     <= '0;
        end else begin
            ip_hw_q <= hw_int;
            if (exc_commit) begin
                cause_exc_q           <= exp_code;
                status_q[STATUS_EXL]  <= 1'b1;
                // Nested exceptions keep the original return address and BD.
                if (!status_q[STATUS_EXL]) begin
                    epc_q      <= exp_epc;
                    cause_bd_q <= exp_bd;
                end
                if (bad_vaddr_wen) begin
                    badvaddr_q <= bad_vaddr;
                end
            end else if (eret_commit) begin
                status_q[STATUS_EXL] <= 1'b0;
            end else if (mtc0_commit) begin
                case (waddr)
                    CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
                    CP0_CAUSE:  ip_sw_q  <= wdata[CAUSE_IP_SW_HI:CAUSE_IP_LO];
                    CP0_EPC:    epc_q    <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (rsel == 3'd0) begin
            case (raddr)
                CP0_BADVADDR: rdata = badvaddr_q;
                CP0_COUNT:    rdata = count;
                CP0_COMPARE:  rdata = compare;
                CP0_STATUS:   rdata = status_q;
                CP0_CAUSE:    rdata = cause_rd;
                CP0_EPC:      rdata = epc_q;
                CP0_PRID:     rdata = PRID_VALUE;
                default:      rdata = '0;
            endcase
        end
    end

    assign allow_interrupt = status_q[STATUS_IE] & ~status_q[STATUS_EXL];
    assign interrupt_flag  = cause_ip & status_q[STATUS_IM_HI:STATUS_IM_LO];
    assign epc_address     = epc_q;

endmodule
